// File: rtl/pipo_shift_engine.sv
// Parallel-in/parallel-out shift register with a sequenced multi-step shift engine.
// One command shifts or rotates by a programmed step count, one step per clock.
module pipo_shift_engine #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  input  logic             start,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [AMT_W-1:0] amount,
  input  logic             ser_in,
  output logic [WIDTH-1:0] out,
  output logic             ser_out,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_e;

  typedef enum logic [1:0] {
    M_ROT = 2'b00,
    M_LOG = 2'b01,
    M_ARI = 2'b10,
    M_SER = 2'b11
  } mode_e;

  state_e           state_q;
  mode_e            mode_q;
  logic             dir_q;
  logic [AMT_W-1:0] cnt_q;
  logic [WIDTH-1:0] out_q;
  logic             ser_out_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] step_d;
  logic             eject_d;
  logic             fill_l;
  logic             fill_r;

  // Single-step result from the latched command; ser_in is taken live.
  always_comb begin
    fill_l = 1'b0;
    fill_r = 1'b0;
    case (mode_q)
      M_ROT: begin
        fill_l = out_q[WIDTH-1];
        fill_r = out_q[0];
      end
      M_LOG: begin
        fill_l = 1'b0;
        fill_r = 1'b0;
      end
      M_ARI: begin
        fill_l = 1'b0;
        fill_r = out_q[WIDTH-1];
      end
      M_SER: begin
        fill_l = ser_in;
        fill_r = ser_in;
      end
      default: begin
        fill_l = 1'b0;
        fill_r = 1'b0;
      end
    endcase
    if (dir) begin
      step_d  = '0;
      eject_d = 1'b0;
    end else begin
      step_d  = '0;
      eject_d = 1'b0;
    end
    if (dir_q) begin
      step_d  = {out_q[WIDTH-2:0], fill_l};
      eject_d = out_q[WIDTH-1];
    end else begin
      step_d  = {fill_r, out_q[WIDTH-1:1]};
      eject_d = out_q[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mode_q    <= M_ROT;
      dir_q     <= 1'b0;
      cnt_q     <= '0;
      out_q     <= '0;
      ser_out_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load) begin
        // Load aborts any command silently; ser_out keeps its last value.
        out_q   <= value;
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              dir_q   <= dir;
              mode_q  <= mode_e'(mode);
              cnt_q   <= amount;
              busy_q  <= 1'b1;
              state_q <= S_RUN;
            end
          end
          S_RUN: begin
            if (cnt_q == '0) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              out_q     <= step_d;
              ser_out_q <= eject_d;
              cnt_q     <= cnt_q - AMT_W'(1);
              if (cnt_q == AMT_W'(1)) begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= S_IDLE;
              end
            end
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign out     = out_q;
  assign ser_out = ser_out_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign zero    = (out_q == '0);

endmodule
